// File: rtl/goertzel_pkg.sv
// Shared constants for the Goertzel coefficient generator: angle constants (Q8.24),
// CORDIC gain (Q2.30), arctangent table, FSM state type and Q2.30 saturation helper.
package goertzel_pkg;

  localparam logic [31:0] TWO_PI        = 32'h0648_7ED5;
  localparam logic [31:0] PI            = 32'h0324_3F6B;
  localparam logic [31:0] HALF_PI       = 32'h0192_1FB5;
  localparam logic [31:0] THREE_HALF_PI = 32'h04B6_5F1F;

  localparam logic [31:0] CORDIC_K = 32'h26DD_3B6A;
  localparam logic signed [33:0] X_INIT = {2'b00, CORDIC_K};

  // atan(2^-i) in Q8.24; entries past 2^-24 underflow to zero
  localparam logic [31:0] ATAN_LUT [0:29] = '{
    32'h00C9_0FDB, 32'h0076_B19C, 32'h003E_B6EC, 32'h001F_D5BB,
    32'h000F_FAAE, 32'h0007_FF55, 32'h0003_FFEB, 32'h0001_FFFD,
    32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000,
    32'h0000_1000, 32'h0000_0800, 32'h0000_0400, 32'h0000_0200,
    32'h0000_0100, 32'h0000_0080, 32'h0000_0040, 32'h0000_0020,
    32'h0000_0010, 32'h0000_0008, 32'h0000_0004, 32'h0000_0002,
    32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REDUCE,
    ST_ROT,
    ST_STORE,
    ST_DONE
  } state_t;

  localparam logic signed [34:0] SAT_MAX = 35'sd2147483647;
  localparam logic signed [34:0] SAT_MIN = -35'sd2147483648;

  function automatic logic [31:0] atan_at(input logic [4:0] i);
    if (i < 5'd30) return ATAN_LUT[i];
    return 32'h0;
  endfunction

  function automatic logic [31:0] sat_q230(input logic signed [34:0] v);
    if (v > SAT_MAX) return 32'h7FFF_FFFF;
    if (v < SAT_MIN) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/cordic_iter.sv
// One combinational CORDIC micro-rotation in rotation mode: (x, y, z, i) -> next x, y, z.
module cordic_iter
  import goertzel_pkg::*;
(
  input  logic signed [33:0] x,
  input  logic signed [33:0] y,
  input  logic signed [31:0] z,
  input  logic        [4:0]  i,
  output logic signed [33:0] x_next,
  output logic signed [33:0] y_next,
  output logic signed [31:0] z_next
);

  logic signed [33:0] x_sh;
  logic signed [33:0] y_sh;
  logic signed [31:0] atan_v;

  assign x_sh   = x >>> i;
  assign y_sh   = y >>> i;
  assign atan_v = $signed(atan_at(i));

  // Zero residual angle rotates in the positive direction
  always_comb begin
    if (!z[31]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_v;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_v;
    end
  end

endmodule

// File: rtl/goertzel_coef_gen.sv
// Converts NF bin angles into Goertzel coefficients 2*cos(w) with one iterative CORDIC.
// Define GOERTZEL_SIN_OUT_EN to also store sin(w) on the sin_o port.
module goertzel_coef_gen
  import goertzel_pkg::*;
#(
  parameter int NF   = 11,
  parameter int ITER = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NF-1:0][31:0]  angle_i,
  output logic                 valid,
  output logic [NF-1:0][31:0]  coef_o
`ifdef GOERTZEL_SIN_OUT_EN
  ,
  output logic [NF-1:0][31:0]  sin_o
`endif
);

  localparam int IW = $clog2(NF + 1);

  state_t             state_reg, state_next;
  logic [31:0]        a_reg;
  logic               neg_reg;
  logic signed [33:0] x_reg, y_reg, x_next, y_next;
  logic signed [31:0] z_reg, z_next;
  logic [4:0]         iter_reg;
  logic [IW-1:0]      indx_reg;
  logic               valid_reg;

  logic signed [31:0] z_fold;
  logic               neg_fold;
  logic               last_bin;
  logic               store_en;
  logic signed [33:0] c_cos;
  logic signed [34:0] cos2;

  assign last_bin = (indx_reg == IW'(NF - 1));
  assign store_en = en && (state_reg == ST_STORE);
  assign c_cos    = neg_reg ? -x_reg : x_reg;
  assign cos2     = {c_cos, 1'b0};
  assign valid    = valid_reg;

  cordic_iter u_iter (
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .i      (iter_reg),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  // Quadrant fold of the already-reduced angle into [-pi/2, pi/2]
  always_comb begin
    z_fold   = $signed(a_reg);
    neg_fold = 1'b0;
    if (a_reg > THREE_HALF_PI) begin
      z_fold = $signed(a_reg - TWO_PI);
    end else if (a_reg > HALF_PI) begin
      z_fold   = $signed(a_reg - PI);
      neg_fold = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (en && !valid_reg) state_next = ST_LOAD;
      ST_LOAD:   if (en) state_next = ST_REDUCE;
      ST_REDUCE: if (en && (a_reg < TWO_PI)) state_next = ST_ROT;
      ST_ROT:    if (en && (iter_reg == 5'(ITER - 1))) state_next = ST_STORE;
      ST_STORE:  if (en) state_next = last_bin ? ST_DONE : ST_LOAD;
      ST_DONE:   state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      neg_reg   <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      iter_reg  <= '0;
      indx_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      case (state_reg)
        ST_LOAD: a_reg <= angle_i[indx_reg];
        ST_REDUCE: begin
          if (a_reg >= TWO_PI) begin
            a_reg <= a_reg - TWO_PI;
          end else begin
            z_reg    <= z_fold;
            neg_reg  <= neg_fold;
            x_reg    <= X_INIT;
            y_reg    <= '0;
            iter_reg <= '0;
          end
        end
        ST_ROT: begin
          x_reg    <= x_next;
          y_reg    <= y_next;
          z_reg    <= z_next;
          iter_reg <= iter_reg + 5'd1;
        end
        ST_STORE: begin
          indx_reg <= indx_reg + 1'b1;
          if (last_bin) valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GOERTZEL_SIN_OUT_EN
  logic signed [33:0] c_sin;
  logic signed [34:0] sin_ext;
  assign c_sin   = neg_reg ? -y_reg : y_reg;
  assign sin_ext = {c_sin[33], c_sin};
`endif

  for (genvar gi = 0; gi < NF; gi++) begin : g_bin
    logic [31:0] coef_reg;

    always_ff @(posedge clk) begin
      if (rst)                                  coef_reg <= '0;
      else if (store_en && indx_reg == IW'(gi)) coef_reg <= sat_q230(cos2);
    end
    assign coef_o[gi] = coef_reg;

`ifdef GOERTZEL_SIN_OUT_EN
    logic [31:0] sin_reg;

    always_ff @(posedge clk) begin
      if (rst)                                  sin_reg <= '0;
      else if (store_en && indx_reg == IW'(gi)) sin_reg <= sat_q230(sin_ext);
    end
    assign sin_o[gi] = sin_reg;
`endif
  end

endmodule

// File: tb/tb_goertzel_coef_gen.sv
// Self-checking bench for goertzel_coef_gen: directed and random angle sets against a real-valued cos/sin model.
module tb_goertzel_coef_gen;
  import goertzel_pkg::*;

  localparam int NF   = 11;
  localparam int ITER = 24;
  localparam real TOL = 1024.0;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [NF-1:0][31:0] angle_i;
  logic                valid;
  logic [NF-1:0][31:0] coef_o;
`ifdef GOERTZEL_SIN_OUT_EN
  logic [NF-1:0][31:0] sin_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] ang [NF];
  real         exp_cos [NF];
  real         exp_sin [NF];
  int          exp_total;
  int          cycles;

  goertzel_coef_gen #(.NF(NF), .ITER(ITER)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .angle_i (angle_i),
    .valid   (valid),
    .coef_o  (coef_o)
`ifdef GOERTZEL_SIN_OUT_EN
    ,
    .sin_o   (sin_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic real ref_val(input logic [31:0] a, input bit want_sin);
    longint unsigned la = {32'h0, a};
    real w = real'(la) / 16777216.0;
    real v = want_sin ? $sin(w) * 1073741824.0 : 2.0 * $cos(w) * 1073741824.0;
    if (v > 2147483647.0)  v = 2147483647.0;
    if (v < -2147483648.0) v = -2147483648.0;
    return v;
  endfunction

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
  endtask

  task automatic check_near(input string tag, input int k, input real obs, input real expv);
    checks++;
    assert (((obs - expv) <= TOL) && ((expv - obs) <= TOL))
      else begin
        failures++;
        $error("FAIL %s[%0d] observed=%0.1f expected=%0.1f", tag, k, obs, expv);
      end
  endtask

  // Expected total cycles: one IDLE edge, then per bin LOAD + REDUCE(1+subs) + ITER + STORE
  task automatic build_model(input int pause_len);
    exp_total = 1 + pause_len;
    for (int k = 0; k < NF; k++) begin
      exp_total += ITER + 3 + int'(ang[k] / TWO_PI);
      exp_cos[k] = ref_val(ang[k], 1'b0);
      exp_sin[k] = ref_val(ang[k], 1'b1);
    end
  endtask

  task automatic apply_angles();
    for (int k = 0; k < NF; k++) angle_i[k] = ang[k];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"}, longint'(valid), 0);
    for (int k = 0; k < NF; k++) begin
      check_eq({tag, "_coef"}, longint'(coef_o[k]), 0);
`ifdef GOERTZEL_SIN_OUT_EN
      check_eq({tag, "_sin"}, longint'(sin_o[k]), 0);
`endif
    end
  endtask

  task automatic check_coefs(input string tag);
    int v;
    for (int k = 0; k < NF; k++) begin
      v = $signed(coef_o[k]);
      $display("%s bin=%0d angle=%08h coef=%08h model=%0.1f", tag, k, ang[k], coef_o[k], exp_cos[k]);
      check_near({tag, "_coef"}, k, real'(v), exp_cos[k]);
`ifdef GOERTZEL_SIN_OUT_EN
      v = $signed(sin_o[k]);
      check_near({tag, "_sin"}, k, real'(v), exp_sin[k]);
`endif
    end
  endtask

  // Runs from reset release until valid, optionally pausing en and disturbing bin 0's angle mid-rotation
  task automatic run_bins(input int pause_at, input int pause_len, input bit scramble,
                          output int n);
    n = 0;
    while (!valid && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (pause_len > 0 && n == pause_at) begin
        en = 1'b0;
        if (scramble) angle_i[0] = $urandom;
      end
      if (pause_len > 0 && n == pause_at + pause_len) en = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_angle();
    logic [31:0] lim = 3 * TWO_PI;
    return $urandom % lim;
  endfunction

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    angle_i = '0;

    // Directed corner angles plus random fill
    ang[0] = 32'h0;
    ang[1] = HALF_PI;
    ang[2] = PI;
    ang[3] = 32'h0218_2A47;
    ang[4] = 32'h0764_3BA1;
    ang[5] = TWO_PI;
    ang[6] = THREE_HALF_PI;
    ang[7] = HALF_PI + 32'd1;
    for (int k = 8; k < NF; k++) ang[k] = rand_angle();
    apply_angles();
    en = 1'b1;
    do_reset();
    check_cleared("reset");
    build_model(0);
    run_bins(0, 0, 1'b0, cycles);
    check_eq("directed_cycles", cycles, exp_total);
    check_coefs("directed");

    // Outputs stay frozen in DONE even when angles change
    for (int k = 0; k < NF; k++) angle_i[k] = $urandom;
    repeat (40) @(posedge clk);
    #1;
    check_eq("done_valid", longint'(valid), 1);
    check_coefs("frozen");

    // Ramp of angles across one turn
    for (int k = 0; k < NF; k++) ang[k] = 32'(k) * 32'h0090_0000;
    apply_angles();
    do_reset();
    build_model(0);
    run_bins(0, 0, 1'b0, cycles);
    check_eq("ramp_cycles", cycles, exp_total);
    check_coefs("ramp");

    // en dropped for 5 clocks mid-rotation of bin 0, with bin 0's angle disturbed
    for (int k = 0; k < NF; k++) ang[k] = rand_angle();
    ang[0] = HALF_PI >> 1;
    apply_angles();
    do_reset();
    build_model(5);
    run_bins(15, 5, 1'b1, cycles);
    check_eq("pause_cycles", cycles, exp_total);
    check_coefs("pause");

    // Reset mid-run clears everything; then a full rerun
    for (int k = 0; k < NF; k++) ang[k] = rand_angle();
    ang[0] = PI;
    apply_angles();
    do_reset();
    build_model(0);
    repeat (70) @(posedge clk);
    #1;
    check_near("partial_coef", 0, real'($signed(coef_o[0])), exp_cos[0]);
    check_eq("partial_last_zero", longint'(coef_o[NF-1]), 0);
    check_eq("partial_valid", longint'(valid), 0);
    do_reset();
    check_cleared("midrst");
    run_bins(0, 0, 1'b0, cycles);
    check_eq("rerun_cycles", cycles, exp_total);
    check_coefs("rerun");

    // Fully random set
    for (int k = 0; k < NF; k++) ang[k] = rand_angle();
    apply_angles();
    do_reset();
    build_model(0);
    run_bins(0, 0, 1'b0, cycles);
    check_eq("random_cycles", cycles, exp_total);
    check_coefs("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
